// File: rtl/cpu_stage_sequencer_if.sv
// Sequencer-to-datapath bundle: fetch/data handshakes, decoded controls, and status.
interface cpu_stage_sequencer_if #(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned RET_WIDTH = 32
);
   logic                 imem_ready;
   logic                 dmem_ready;
   logic                 is_load;
   logic                 is_store;
   logic                 is_halt;
   logic                 reg_we_req;
   logic [PC_WIDTH-1:0]  npc;
   logic                 resume;

   logic [2:0]           stage;
   logic [PC_WIDTH-1:0]  pc;
   logic                 imem_req;
   logic                 dmem_req;
   logic                 dmem_we;
   logic                 decoder_rst;
   logic                 alu_rst;
   logic                 reg_we;
   logic                 halted;
   logic                 fault;
   logic [RET_WIDTH-1:0] retired;

   // Environment side: drives decoded controls and ready handshakes.
   modport master (
      output imem_ready, dmem_ready, is_load, is_store, is_halt, reg_we_req, npc, resume,
      input  stage, pc, imem_req, dmem_req, dmem_we, decoder_rst, alu_rst, reg_we,
             halted, fault, retired
   );

   // Sequencer side.
   modport slave (
      input  imem_ready, dmem_ready, is_load, is_store, is_halt, reg_we_req, npc, resume,
      output stage, pc, imem_req, dmem_req, dmem_we, decoder_rst, alu_rst, reg_we,
             halted, fault, retired
   );
endinterface

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle CPU stage sequencer: IF/RR/EX/MA/RW with HALT, sticky FAULT and
// bounded memory waits.
module cpu_stage_sequencer #(
   parameter int unsigned          PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'('h7FFC),
   parameter int unsigned          TIMEOUT   = 16,
   parameter int unsigned          RET_WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst,
   cpu_stage_sequencer_if.slave  bus
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IF    = 3'd0,
      S_RR    = 3'd1,
      S_EX    = 3'd2,
      S_MA    = 3'd3,
      S_RW    = 3'd4,
      S_HALT  = 3'd5,
      S_FAULT = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [RET_WIDTH-1:0]  retired_q, retired_d;
   logic [CNT_W-1:0]      wait_q, wait_d;
   logic                  imem_req_q, imem_req_d;
   logic                  decoder_rst_q, decoder_rst_d;
   logic                  alu_rst_q, alu_rst_d;
   logic                  halted_q, halted_d;
   logic                  fault_q, fault_d;
   logic                  mem_op;

   assign mem_op = bus.is_load | bus.is_store;

   // Next-state, PC, retire count and wait-counter logic.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      wait_d    = wait_q;
      unique case (state_q)
         S_IF: begin
            if (bus.imem_ready) begin
               state_d = S_RR;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         S_RR: state_d = S_EX;
         S_EX: begin
            state_d = S_MA;
            wait_d  = '0;
         end
         S_MA: begin
            if (!mem_op || bus.dmem_ready) begin
               state_d = S_RW;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         S_RW: begin
            retired_d = retired_q + RET_WIDTH'(1);
            if (bus.is_halt) begin
               state_d = S_HALT;
            end else if (bus.npc[1:0] != 2'b00) begin
               state_d = S_FAULT;
            end else begin
               pc_d    = bus.npc;
               state_d = S_IF;
               wait_d  = '0;
            end
         end
         S_HALT: begin
            if (bus.resume) begin
               pc_d    = pc_q + PC_WIDTH'(4);
               state_d = S_IF;
               wait_d  = '0;
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase

      // State-only strobes are registered from the next state so they align with stage.
      imem_req_d    = (state_d == S_IF);
      decoder_rst_d = (state_d == S_RR);
      alu_rst_d     = (state_d == S_EX);
      halted_d      = (state_d == S_HALT);
      fault_d       = (state_d == S_FAULT);
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IF;
         pc_q          <= RESET_PC;
         retired_q     <= '0;
         wait_q        <= '0;
         imem_req_q    <= 1'b1;
         decoder_rst_q <= 1'b0;
         alu_rst_q     <= 1'b0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         retired_q     <= retired_d;
         wait_q        <= wait_d;
         imem_req_q    <= imem_req_d;
         decoder_rst_q <= decoder_rst_d;
         alu_rst_q     <= alu_rst_d;
         halted_q      <= halted_d;
         fault_q       <= fault_d;
      end
   end

   assign bus.stage       = 3'(state_q);
   assign bus.pc          = pc_q;
   assign bus.retired     = retired_q;
   assign bus.imem_req    = imem_req_q;
   assign bus.decoder_rst = decoder_rst_q;
   assign bus.alu_rst     = alu_rst_q;
   assign bus.halted      = halted_q;
   assign bus.fault       = fault_q;
   // Data strobes qualify the MA/RW state with the decoded instruction held by the decoder.
   assign bus.dmem_req    = (state_q == S_MA) & mem_op;
   assign bus.dmem_we     = (state_q == S_MA) & bus.is_store;
   assign bus.reg_we      = (state_q == S_RW) & bus.reg_we_req;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Bench for cpu_stage_sequencer: per-instruction reference traces built from the
// stage rules, compared cycle by cycle against the DUT.
module tb_cpu_stage_sequencer;

   localparam int unsigned PCW  = 32;
   localparam int unsigned RETW = 4;
   localparam int unsigned TMO  = 4;
   localparam logic [31:0] RST_PC = 32'h7FFC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cpu_stage_sequencer_if #(.PC_WIDTH(PCW), .RET_WIDTH(RETW)) bus ();

   cpu_stage_sequencer #(
      .PC_WIDTH(PCW), .RESET_PC(RST_PC), .TIMEOUT(TMO), .RET_WIDTH(RETW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   // One expected cycle: inputs to apply plus the architectural state it should show.
   typedef struct {
      bit          ir, dr, res, ld, st, hlt, we;
      logic [31:0] npc;
      int          stg;
      logic [31:0] pc;
      int          ret;
   } cyc_t;

   cyc_t        plan[$];
   logic [46:0] obs[$];
   logic [31:0] m_pc;
   int          m_ret;
   bit          m_fault;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic bit rnd();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic void reset_model();
      m_pc = RST_PC; m_ret = 0; m_fault = 1'b0;
   endfunction

   function automatic void add(int stg, bit ir, bit dr, bit res, cyc_t t);
      t.stg = stg; t.ir = ir; t.dr = dr; t.res = res; t.pc = m_pc; t.ret = m_ret;
      plan.push_back(t);
   endfunction

   function automatic void add_fault(cyc_t t);
      m_fault = 1'b1;
      for (int c = 0; c < 6; c++) add(6, rnd(), rnd(), rnd(), t);
   endfunction

   // Expected trace of one instruction: wi/wd = ready-low cycles before ready, rdel = HALT cycles before resume.
   function automatic void build_instr(int wi, int wd, bit ld, bit st, bit hlt, bit we,
                                       logic [31:0] npcv, int rdel);
      cyc_t t;
      t.ld = ld; t.st = st; t.hlt = hlt; t.we = we; t.npc = npcv;
      for (int c = 0; c < int'(TMO); c++) begin
         add(0, (c == wi), rnd(), rnd(), t);
         if (c == wi) break;
         if (c == int'(TMO) - 1) begin add_fault(t); return; end
      end
      add(1, rnd(), rnd(), rnd(), t);
      add(2, rnd(), rnd(), rnd(), t);
      if (!(ld || st)) begin
         add(3, rnd(), rnd(), rnd(), t);
      end else begin
         for (int c = 0; c < int'(TMO); c++) begin
            add(3, rnd(), (c == wd), rnd(), t);
            if (c == wd) break;
            if (c == int'(TMO) - 1) begin add_fault(t); return; end
         end
      end
      add(4, rnd(), rnd(), rnd(), t);
      m_ret = (m_ret + 1) % (1 << RETW);
      if (hlt) begin
         for (int c = 0; c <= rdel; c++) add(5, rnd(), rnd(), (c == rdel), t);
         m_pc = m_pc + 32'd4;
      end else if (npcv[1:0] != 2'b00) begin
         add_fault(t);
      end else begin
         m_pc = npcv;
      end
   endfunction

   // Output image: {stage, imem_req, decoder_rst, alu_rst, dmem_req, dmem_we, reg_we, halted, fault, retired, pc}.
   function automatic logic [46:0] exp_vec(cyc_t e);
      return {3'(e.stg), (e.stg == 0), (e.stg == 1), (e.stg == 2),
              (e.stg == 3) && (e.ld || e.st), (e.stg == 3) && e.st,
              (e.stg == 4) && e.we, (e.stg == 5), (e.stg == 6), 4'(e.ret), e.pc};
   endfunction

   function automatic logic [46:0] obs_vec();
      return {bus.stage, bus.imem_req, bus.decoder_rst, bus.alu_rst, bus.dmem_req,
              bus.dmem_we, bus.reg_we, bus.halted, bus.fault, bus.retired, bus.pc};
   endfunction

   // Apply plan[0..upto-1] one cycle each and record outputs mid-cycle.
   task automatic run_plan(int upto);
      obs.delete();
      for (int i = 0; i < upto && i < plan.size(); i++) begin
         bus.imem_ready = plan[i].ir;  bus.dmem_ready = plan[i].dr;
         bus.resume     = plan[i].res; bus.is_load    = plan[i].ld;
         bus.is_store   = plan[i].st;  bus.is_halt    = plan[i].hlt;
         bus.reg_we_req = plan[i].we;  bus.npc        = plan[i].npc;
         #1;
         obs.push_back(obs_vec());
         @(posedge clk); #1;
      end
   endtask

   task automatic assert_rst();
      #1 rst = 1'b0;
      #1;
      reset_model();
   endtask

   task automatic release_rst();
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic idle_inputs();
      bus.imem_ready = 0; bus.dmem_ready = 0; bus.resume = 0; bus.is_load = 0;
      bus.is_store = 0; bus.is_halt = 0; bus.reg_we_req = 0; bus.npc = '0;
   endtask

   task automatic test_reset();
      logic [46:0] rv;
      rv = {3'd0, 8'b1000_0000, 4'd0, RST_PC};
      idle_inputs();
      @(posedge clk); #1;
      assert_rst();
      n_cmp++;
      if (obs_vec() !== rv) begin
         n_bad++; $display("FAIL reset_async got=%h exp=%h", obs_vec(), rv);
      end
      bus.imem_ready = 1; bus.dmem_ready = 1; bus.resume = 1;
      @(posedge clk); #1;
      n_cmp++;
      if (obs_vec() !== rv) begin
         n_bad++; $display("FAIL reset_held got=%h exp=%h", obs_vec(), rv);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.stage !== 3'd0) begin
         n_bad++; $display("FAIL reset_release_stage got=%0d exp=0", bus.stage);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.stage !== 3'd1) begin
         n_bad++; $display("FAIL reset_first_edge got=%0d exp=1", bus.stage);
      end
      idle_inputs();
      assert_rst();
      release_rst();
   endtask

   task automatic test_zero_wait_alu();
      int exp_stg[5] = '{0, 1, 2, 3, 4};
      int n_we = 0;
      plan.delete();
      build_instr(0, 0, 0, 0, 0, 1, 32'h8000, 0);
      run_plan(plan.size());
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL zero_wait cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
         n_cmp++;
         if (int'(obs[i][46:44]) != exp_stg[i]) begin
            n_bad++; $display("FAIL zero_wait_stage cyc%0d got=%0d exp=%0d", i, obs[i][46:44], exp_stg[i]);
         end
         n_we += int'(obs[i][38]);
      end
      n_cmp++;
      if (n_we != 1) begin n_bad++; $display("FAIL zero_wait_reg_we got=%0d exp=1", n_we); end
      n_cmp++;
      if ({bus.stage, bus.pc, bus.retired} !== {3'd0, 32'h8000, 4'd1}) begin
         n_bad++; $display("FAIL zero_wait_end got=%0d/%h/%0d exp=0/8000/1", bus.stage, bus.pc, bus.retired);
      end
   endtask

   task automatic test_load_wait();
      int n_ma = 0;
      plan.delete();
      build_instr(2, 3, 1, 0, 0, 1, 32'h8004, 0);
      run_plan(plan.size());
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL load_wait cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
         if (obs[i][46:44] == 3'd3) begin
            n_ma++;
            n_cmp++;
            if (obs[i][40:39] !== 2'b10) begin
               n_bad++; $display("FAIL load_strobes cyc%0d got=%b exp=10", i, obs[i][40:39]);
            end
         end
      end
      n_cmp++;
      if (n_ma != 4) begin n_bad++; $display("FAIL load_ma_len got=%0d exp=4", n_ma); end
      n_cmp++;
      if ({bus.stage, bus.pc} !== {3'd0, 32'h8004}) begin
         n_bad++; $display("FAIL load_end got=%0d/%h exp=0/8004", bus.stage, bus.pc);
      end
   endtask

   task automatic test_halt_resume();
      bit saw_halt = 0;
      plan.delete();
      build_instr(0, 0, 0, 1, 0, 0, 32'h8010, 0);
      build_instr(1, 0, 0, 0, 1, 0, 32'h8020, 3);
      run_plan(plan.size());
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL halt cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
         if (obs[i][37] && obs[i][31:0] == 32'h8010) saw_halt = 1;
      end
      n_cmp++;
      if (!saw_halt) begin n_bad++; $display("FAIL halt_seen got=0 exp=1"); end
      n_cmp++;
      if ({bus.stage, bus.pc} !== {3'd0, 32'h8014}) begin
         n_bad++; $display("FAIL halt_resume got=%0d/%h exp=0/8014", bus.stage, bus.pc);
      end
   endtask

   task automatic test_misaligned();
      logic [3:0] r0;
      r0 = bus.retired;
      plan.delete();
      build_instr(1, 0, 0, 0, 0, 1, 32'h8002, 0);
      run_plan(plan.size());
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL misaligned cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
      end
      n_cmp++;
      if ({bus.fault, bus.stage, bus.pc, bus.retired} !== {1'b1, 3'd6, 32'h8014, 4'(r0 + 4'd1)}) begin
         n_bad++; $display("FAIL misaligned_end got=%b/%0d/%h/%0d exp=1/6/8014/%0d",
                           bus.fault, bus.stage, bus.pc, bus.retired, 4'(r0 + 4'd1));
      end
   endtask

   task automatic test_store_timeout();
      int n_ma = 0;
      assert_rst(); release_rst();
      plan.delete();
      build_instr(0, 99, 0, 1, 0, 0, 32'h8000, 0);
      run_plan(plan.size());
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL store_timeout cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
         if (obs[i][46:44] == 3'd3) n_ma++;
      end
      n_cmp++;
      if (n_ma != 4) begin n_bad++; $display("FAIL store_ma_len got=%0d exp=4", n_ma); end
      n_cmp++;
      if ({bus.fault, bus.pc} !== {1'b1, RST_PC}) begin
         n_bad++; $display("FAIL store_fault got=%b/%h exp=1/%h", bus.fault, bus.pc, RST_PC);
      end
      assert_rst(); release_rst();
   endtask

   task automatic test_retire_wrap();
      plan.delete();
      for (int k = 0; k < 16; k++) build_instr(0, 0, 0, 0, 0, 1, m_pc + 32'd4, 0);
      run_plan(plan.size());
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL retire_wrap cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
      end
      n_cmp++;
      if (bus.retired !== 4'd0) begin
         n_bad++; $display("FAIL retire_wrap_end got=%0d exp=0", bus.retired);
      end
   endtask

   task automatic test_reset_mid_ma();
      int ma_idx = -1;
      plan.delete();
      build_instr(0, 0, 0, 0, 0, 1, m_pc + 32'd4, 0);
      build_instr(0, 3, 1, 0, 0, 1, m_pc + 32'd8, 0);
      foreach (plan[i]) if (plan[i].stg == 3 && plan[i].ld && ma_idx < 0) ma_idx = i;
      run_plan(ma_idx + 2);
      foreach (obs[i]) begin
         n_cmp++;
         if (obs[i] !== exp_vec(plan[i])) begin
            n_bad++; $display("FAIL pre_reset cyc%0d got=%h exp=%h", i, obs[i], exp_vec(plan[i]));
         end
      end
      bus.dmem_ready = 1'b0;
      assert_rst();
      n_cmp++;
      if (obs_vec() !== {3'd0, 8'b1000_0000, 4'd0, RST_PC}) begin
         n_bad++; $display("FAIL reset_mid_ma got=%h exp=%h", obs_vec(), {3'd0, 8'b1000_0000, 4'd0, RST_PC});
      end
      release_rst();
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         int           wi, wd;
         bit           ld, st, hlt;
         logic [31:0]  nv;
         wi  = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
         wd  = int'($urandom_range(0, 4));
         ld  = rnd(); st = ld ? 1'b0 : rnd();
         hlt = ($urandom_range(0, 7) == 0);
         nv  = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) nv[1:0] = 2'($urandom_range(1, 3));
         plan.delete();
         build_instr(wi, wd, ld, st, hlt, rnd(), nv, int'($urandom_range(0, 3)));
         run_plan(plan.size());
         foreach (obs[i]) begin
            n_cmp++;
            if (obs[i] !== exp_vec(plan[i])) begin
               n_bad++; $display("FAIL random k%0d cyc%0d got=%h exp=%h", k, i, obs[i], exp_vec(plan[i]));
            end
         end
         if (m_fault) begin assert_rst(); release_rst(); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset_model();
      test_reset();
      test_zero_wait_alu();
      test_load_wait();
      test_halt_resume();
      test_misaligned();
      test_store_timeout();
      test_retire_wrap();
      test_reset_mid_ma();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
